// File: rtl/latch_status_pkg.sv
// Shared types and sizing helpers for the high-latch status controller.
package latch_status_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CLEAR = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

  function automatic int unsigned idx_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/latch_status_ctrl_lsb_prio_enc.sv
// Lowest-set-bit priority encoder with any/multi flags.
module lsb_prio_enc
  import latch_status_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any   = |vec;
  assign multi = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/latch_status_ctrl.sv
// First-event capture, event counting, irq and timed software clear for the high-latch.
module latch_status_ctrl
  import latch_status_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned CLR_CYCLES = 4,
  parameter  int unsigned CNT_W      = CNT_W_DEF,
  localparam int unsigned IDX_W      = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] latched,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic             latch_resetn,
  output logic             irq,
  output logic             first_valid,
  output logic [IDX_W-1:0] first_idx,
  output logic             first_multi,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned      CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state;
  logic [CLR_W-1:0]   clr_cnt;
  logic               sw_clr;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   new_bits;
  logic [IDX_W-1:0]   pe_idx;
  logic               pe_any;
  logic               pe_multi;

  assign new_bits = latched & ~prev;

  lsb_prio_enc #(.WIDTH(WIDTH)) u_prio (
    .vec   (new_bits),
    .idx   (pe_idx),
    .any   (pe_any),
    .multi (pe_multi)
  );

  // Outputs are assigned on state transitions so they track the visible state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      clr_cnt      <= CLR_LOAD;
      sw_clr       <= 1'b0;
      latch_resetn <= 1'b0;
      clr_ack      <= 1'b0;
      irq          <= 1'b0;
      first_valid  <= 1'b0;
      first_idx    <= '0;
      first_multi  <= 1'b0;
      event_count  <= '0;
      prev         <= '0;
    end else begin
      clr_ack <= 1'b0;
      case (state)
        RUN: begin
          prev <= latched;
          if (pe_any) begin
            if (event_count != CNT_MAX) event_count <= event_count + CNT_W'(1);
            if (!first_valid) begin
              first_valid <= 1'b1;
              first_idx   <= pe_idx;
              first_multi <= pe_multi;
            end
          end
          if (clr_req) begin
            state        <= CLEAR;
            clr_cnt      <= CLR_LOAD;
            sw_clr       <= 1'b1;
            latch_resetn <= 1'b0;
            irq          <= 1'b0;
          end else begin
            latch_resetn <= 1'b1;
            irq          <= |(latched & ~irq_mask);
          end
        end
        CLEAR: begin
          irq <= 1'b0;
          if (clr_cnt == '0) begin
            state        <= ACK;
            latch_resetn <= 1'b1;
            clr_ack      <= sw_clr;
          end else begin
            clr_cnt <= clr_cnt - CLR_W'(1);
          end
        end
        ACK: begin
          state        <= RUN;
          latch_resetn <= 1'b1;
          irq          <= |(latched & ~irq_mask);
          sw_clr       <= 1'b0;
          first_valid  <= 1'b0;
          first_idx    <= '0;
          first_multi  <= 1'b0;
          event_count  <= '0;
          prev         <= '0;
        end
        default: begin
          state        <= CLEAR;
          clr_cnt      <= CLR_LOAD;
          sw_clr       <= 1'b0;
          latch_resetn <= 1'b0;
          irq          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_status_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_latch_status_ctrl;

  localparam int W   = 32;
  localparam int CLR = 4;

  logic        clk;
  logic        reset;
  logic [31:0] latched;
  logic [31:0] irq_mask;
  logic        clr_req;
  logic        clr_ack;
  logic        latch_resetn;
  logic        irq;
  logic        first_valid;
  logic [4:0]  first_idx;
  logic        first_multi;
  logic [15:0] event_count;

  latch_status_ctrl #(.WIDTH(W), .CLR_CYCLES(CLR), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .latched      (latched),
    .irq_mask     (irq_mask),
    .clr_req      (clr_req),
    .clr_ack      (clr_ack),
    .latch_resetn (latch_resetn),
    .irq          (irq),
    .first_valid  (first_valid),
    .first_idx    (first_idx),
    .first_multi  (first_multi),
    .event_count  (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: clear is a countdown of remaining low cycles, ACK a one-shot flag.
  bit          m_valid = 0;
  int          m_clear_left;
  bit          m_in_ack;
  bit          m_sw;
  logic [31:0] m_prev;
  logic        e_lrn, e_ack, e_irq, e_fv, e_multi;
  int          e_idx;
  int          e_cnt;

  always @(posedge clk) begin : model
    logic [31:0] nw;
    bit found;
    if (reset) begin
      m_valid = 1; m_clear_left = CLR; m_in_ack = 0; m_sw = 0; m_prev = '0;
      e_lrn = 0; e_ack = 0; e_irq = 0; e_fv = 0; e_multi = 0; e_idx = 0; e_cnt = 0;
    end else begin
      e_ack = 0;
      if (m_in_ack) begin
        m_in_ack = 0; m_sw = 0; m_prev = '0;
        e_fv = 0; e_idx = 0; e_multi = 0; e_cnt = 0; e_lrn = 1;
        e_irq = |(latched & ~irq_mask);
      end else if (m_clear_left > 0) begin
        m_clear_left--;
        e_irq = 0;
        if (m_clear_left == 0) begin
          m_in_ack = 1; e_ack = m_sw; e_lrn = 1;
        end
      end else begin
        nw = latched & ~m_prev;
        m_prev = latched;
        if (nw != 0) begin
          if (e_cnt < 65535) e_cnt++;
          if (!e_fv) begin
            e_fv = 1;
            e_multi = ($countones(nw) > 1);
            found = 0;
            for (int i = 0; i < W; i++) begin
              if (!found && nw[i]) begin e_idx = i; found = 1; end
            end
          end
        end
        if (clr_req) begin
          m_clear_left = CLR; m_sw = 1; e_lrn = 0; e_irq = 0;
        end else begin
          e_irq = |(latched & ~irq_mask);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("latch_resetn", 32'(latch_resetn), 32'(e_lrn));
      check("clr_ack",      32'(clr_ack),      32'(e_ack));
      check("irq",          32'(irq),          32'(e_irq));
      check("first_valid",  32'(first_valid),  32'(e_fv));
      check("first_idx",    32'(first_idx),    32'(e_idx));
      check("first_multi",  32'(first_multi),  32'(e_multi));
      check("event_count",  32'(event_count),  32'(e_cnt));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts cycles with latch_resetn low, flagging any irq, and stops on ACK.
  task automatic measure_clear(input string nm, output int lows);
    lows = 0;
    while (!latch_resetn && lows < 20) begin
      check({nm, "_irq_low"}, 32'(irq), 32'd0);
      lows++;
      wait_cyc(1);
    end
  endtask

  task automatic do_clear();
    int k;
    clr_req = 1'b1;
    wait_cyc(1);
    clr_req = 1'b0;
    latched = '0;
    k = 0;
    while (!clr_ack && k < 20) begin k++; wait_cyc(1); end
    check("clear_ack_seen", 32'(clr_ack), 32'd1);
    wait_cyc(1);
  endtask

  initial begin
    int lows;
    reset = 1'b1; latched = '0; irq_mask = '0; clr_req = 1'b0;
    wait_cyc(2);
    reset = 1'b0;

    // Power-on clear: four low cycles, no ack, outputs idle.
    measure_clear("por", lows);
    check("por_low_cycles", 32'(lows), 32'd4);
    check("por_no_ack",     32'(clr_ack), 32'd0);
    check("por_fv",         32'(first_valid), 32'd0);
    check("por_cnt",        32'(event_count), 32'd0);
    wait_cyc(1);

    latched = 32'h0000_0020;
    wait_cyc(1);
    check("single_fv",    32'(first_valid), 32'd1);
    check("single_idx",   32'(first_idx),   32'd5);
    check("single_multi", 32'(first_multi), 32'd0);
    check("single_cnt",   32'(event_count), 32'd1);
    latched = 32'h0000_0021;
    wait_cyc(1);
    check("frozen_idx", 32'(first_idx),   32'd5);
    check("second_cnt", 32'(event_count), 32'd2);

    do_clear();
    latched = 32'h0000_0C00;
    wait_cyc(1);
    check("multi_idx",   32'(first_idx),   32'd10);
    check("multi_flag",  32'(first_multi), 32'd1);
    check("multi_cnt",   32'(event_count), 32'd1);

    irq_mask = 32'hFFFF_FFFE;
    latched  = 32'h0000_0002;
    wait_cyc(1);
    check("irq_masked", 32'(irq), 32'd0);
    latched = 32'h0000_0003;
    wait_cyc(1);
    check("irq_unmasked", 32'(irq), 32'd1);
    irq_mask = 32'hFFFF_FFFF;
    wait_cyc(1);
    check("irq_live_mask", 32'(irq), 32'd0);

    // Seven events, then a software clear with a persistent input bit.
    do_clear();
    irq_mask = '0;
    for (int i = 0; i < 7; i++) begin
      latched = latched | (32'h10 << i);
      wait_cyc(1);
    end
    check("seven_cnt", 32'(event_count), 32'd7);
    check("seven_idx", 32'(first_idx),   32'd4);
    check("seven_irq", 32'(irq),         32'd1);
    clr_req = 1'b1;
    wait_cyc(1);
    clr_req = 1'b0;
    latched = 32'h0000_0008;
    measure_clear("sw", lows);
    check("sw_low_cycles", 32'(lows), 32'd4);
    check("sw_ack",        32'(clr_ack), 32'd1);
    wait_cyc(1);
    check("sw_ack_once", 32'(clr_ack),     32'd0);
    check("sw_fv_zero",  32'(first_valid), 32'd0);
    check("sw_cnt_zero", 32'(event_count), 32'd0);
    wait_cyc(1);
    check("recap_fv",  32'(first_valid), 32'd1);
    check("recap_idx", 32'(first_idx),   32'd3);
    check("recap_cnt", 32'(event_count), 32'd1);

    // Saturation: a rising bit every cycle.
    for (int i = 0; i < 65540; i++) begin
      latched = (i % 2 == 0) ? 32'h1 : 32'h2;
      wait_cyc(1);
    end
    check("sat_cnt", 32'(event_count), 32'hFFFF);
    latched = 32'h4;
    wait_cyc(1);
    check("sat_hold", 32'(event_count), 32'hFFFF);

    // Reset in the middle of a software clear.
    clr_req = 1'b1;
    wait_cyc(1);
    clr_req = 1'b0;
    latched = '0;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    measure_clear("rst_mid", lows);
    check("rst_mid_low_cycles", 32'(lows), 32'd4);
    check("rst_mid_no_ack",     32'(clr_ack), 32'd0);
    wait_cyc(1);

    // Randomized traffic; the latch is modelled as sticky and wiped while held in reset.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      if (!latch_resetn) latched = '0;
      else if ($urandom_range(0, 3) == 0) latched = latched | (32'h1 << $urandom_range(0, 31));
      else if ($urandom_range(0, 15) == 0) latched = latched | ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) irq_mask = $urandom;
      if (clr_ack) clr_req = 1'b0;
      else if (!clr_req && $urandom_range(0, 63) == 0) clr_req = 1'b1;
      wait_cyc(1);
    end
    reset = 1'b0;
    clr_req = 1'b0;
    wait_cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
